// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point constants and rounding helper
package fp_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_BIAS  = (1 << (DEF_EXP_W - 1)) - 1;

    // Decide whether the truncated fraction gets +1; unknown modes fall back to RNE
    function automatic logic round_up(
        input logic [2:0] rm,
        input logic       sign,
        input logic       lsb,
        input logic       guard,
        input logic       sticky
    );
        logic inc;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = (guard | sticky) & sign;
            RM_RUP:  inc = (guard | sticky) & ~sign;
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - leading-zero counter; an all-zero input reports WIDTH
module lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                cnt_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fcvt_int2fp_pipe.sv
// rtl/fcvt_int2fp_pipe.sv - 3-stage integer to IEEE float converter with backpressure
module fcvt_int2fp_pipe
    import fp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        rs1,
    input  logic                   is_unsigned,
    input  logic [2:0]             rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic                   fflag_nx
);

    localparam int LZ_W  = $clog2(XLEN) + 1;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    // Fraction below the hidden bit, padded so guard/sticky always exist
    localparam int EXT_W = XLEN + MAN_W + 1;

    logic stall;

    // Stage 1 state
    logic            v1_q;
    logic            sign1_q, sign_d;
    logic [XLEN-1:0] mag1_q, mag_d;
    logic [2:0]      rm1_q;

    // Stage 2 state; the normalised MSB is implicit so only the bits below it are kept
    logic              v2_q;
    logic              sign2_q;
    logic [XLEN-2:0]   norm2_q, norm_d;
    logic [EXP_W-1:0]  exp2_q, exp_d;
    logic              zero2_q, zero_d;
    logic [2:0]        rm2_q;
    logic [LZ_W-1:0]   lz;

    // Stage 3 (output) state
    logic                 v3_q;
    logic [EXP_W+MAN_W:0] out_q, out_d;
    logic                 nx_q, nx_d;

    logic [EXT_W-1:0] ext;
    logic [MAN_W-1:0] frac_t;
    logic             guard, sticky, inc;
    logic [MAN_W:0]   frac_r;
    logic [EXP_W-1:0] bexp;

    // Reset overrides the stall so in_ready stays high while resetting
    assign stall     = v3_q & ~out_ready & ~resetn;
    assign in_ready  = ~stall;
    assign out_valid = v3_q;
    assign out       = out_q;
    assign fflag_nx  = nx_q;

    // S1: split into sign and magnitude; -2^(XLEN-1) negates to itself, which is the correct magnitude
    always_comb begin
        sign_d = ~is_unsigned & rs1[XLEN-1];
        mag_d  = sign_d ? (~rs1 + XLEN'(1)) : rs1;
    end

    lzc #(.WIDTH(XLEN), .CNT_W(LZ_W)) u_lzc (
        .data_i (mag1_q),
        .cnt_o  (lz)
    );

    // S2: normalise; the MSB shifts out so shifting the lower bits is enough
    always_comb begin
        norm_d = mag1_q[XLEN-2:0] << lz;
        exp_d  = EXP_W'(XLEN - 1) - EXP_W'(lz);
        zero_d = (lz == LZ_W'(XLEN));
    end

    // S3: split off guard/sticky, round, and pack; a fraction carry bumps the exponent
    always_comb begin
        ext    = {norm2_q, {(MAN_W + 2){1'b0}}};
        frac_t = ext[EXT_W-1 -: MAN_W];
        guard  = ext[EXT_W-1-MAN_W];
        sticky = |ext[EXT_W-2-MAN_W:0];
        inc    = round_up(rm2_q, sign2_q, frac_t[0], guard, sticky);
        frac_r = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
        bexp   = exp2_q + EXP_W'(BIAS) + {{(EXP_W-1){1'b0}}, frac_r[MAN_W]};
        if (zero2_q) begin
            out_d = '0;
            nx_d  = 1'b0;
        end else begin
            out_d = {sign2_q, bexp, frac_r[MAN_W-1:0]};
            nx_d  = guard | sticky;
        end
    end

    // Valid bits and the visible result register; everything holds on stall
    always_ff @(posedge clk) begin
        if (resetn) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            out_q <= '0;
            nx_q  <= 1'b0;
        end else if (!stall) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                out_q <= out_d;
                nx_q  <= nx_d;
            end
        end
    end

    // Datapath registers advance with the valids and need no reset
    always_ff @(posedge clk) begin
        if (!stall) begin
            sign1_q <= sign_d;
            mag1_q  <= mag_d;
            rm1_q   <= rm;
            sign2_q <= sign1_q;
            norm2_q <= norm_d;
            exp2_q  <= exp_d;
            zero2_q <= zero_d;
            rm2_q   <= rm1_q;
        end
    end

endmodule

// File: tb/tb_fcvt_int2fp_pipe.sv
// tb/tb_fcvt_int2fp_pipe.sv - self-checking bench for fcvt_int2fp_pipe
module tb_fcvt_int2fp_pipe;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1 = '0;
    logic        is_unsigned = 1'b0;
    logic [2:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        fflag_nx;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    typedef struct packed {
        logic [31:0] o;
        logic        nx;
    } exp_t;

    typedef struct {
        logic [31:0] op;
        logic        uns;
        logic [2:0]  r;
        logic [31:0] eo;
        logic        enx;
    } vec_t;

    exp_t exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_out;
    logic        prev_nx;

    fcvt_int2fp_pipe dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rs1         (rs1),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .fflag_nx    (fflag_nx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: exact integer value rounded by comparing the discarded remainder to half an ulp
    function automatic exp_t model(input logic [31:0] op, input logic uns, input logic [2:0] r);
        exp_t res;
        longint unsigned mag, q, rem, half;
        logic s;
        int e, shift, mode;
        logic up;
        s   = !uns && op[31];
        mag = op;
        if (s) mag = 64'h1_0000_0000 - mag;
        if (mag == 0) begin
            res.o  = 32'h0;
            res.nx = 1'b0;
            return res;
        end
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        mode = (r > 4) ? 0 : int'(r);
        if (e <= 23) begin
            q   = mag << (23 - e);
            rem = 0;
            up  = 1'b0;
        end else begin
            shift = e - 23;
            q     = mag >> shift;
            rem   = mag - (q << shift);
            half  = 64'd1 << (shift - 1);
            case (mode)
                0:       up = (rem > half) || (rem == half && q[0]);
                1:       up = 1'b0;
                2:       up = (rem != 0) && s;
                3:       up = (rem != 0) && !s;
                default: up = (rem >= half);
            endcase
        end
        q = q + longint'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e++;
        end
        res.o  = {s, 8'(e + 127), q[22:0]};
        res.nx = (rem != 0);
        return res;
    endfunction

    // Scoreboard and stall observer, sampled on the falling edge
    always @(negedge clk) begin
        if (resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_out", 64'({out, fflag_nx}), 64'({prev_out, prev_nx}));
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", 64'(in_ready), 64'd0);
                stall_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h with nothing outstanding", out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", 64'({out, fflag_nx}), 64'({e.o, e.nx}));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            prev_nx    = fflag_nx;
        end
    end

    task automatic send(input logic [31:0] op, input logic uns, input logic [2:0] r, input exp_t e);
        logic ok;
        int   tries;
        ok = 1'b0;
        tries = 0;
        rs1 = op;
        is_unsigned = uns;
        rm = r;
        in_valid = 1'b1;
        while (!ok && tries < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (ok) exp_q.push_back(e);
        else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low, got %b expected 1", in_ready);
        end
    endtask

    task automatic send_m(input logic [31:0] op, input logic uns, input logic [2:0] r);
        send(op, uns, r, model(op, uns, r));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 300);
            2:       v = (32'h1 << $urandom_range(0, 31)) | ($urandom & 32'h1FF);
            default: v = 32'hFFFF_FFFF - $urandom_range(0, 1000);
        endcase
        return v;
    endfunction

    vec_t vecs[16];
    bit   rnd_done;

    initial begin
        vecs[0]  = '{32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0};
        vecs[2]  = '{32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1};
        vecs[3]  = '{32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1};
        vecs[4]  = '{32'h0100_0001, 1'b0, 3'd1, 32'h4B80_0000, 1'b1};
        vecs[5]  = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1};
        vecs[6]  = '{32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0};
        vecs[7]  = '{32'hFEFF_FFFF, 1'b0, 3'd2, 32'hCB80_0001, 1'b1};
        vecs[8]  = '{32'hFEFF_FFFF, 1'b0, 3'd3, 32'hCB80_0000, 1'b1};
        vecs[9]  = '{32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0};
        vecs[10] = '{32'h0000_0000, 1'b0, 3'd2, 32'h0000_0000, 1'b0};
        vecs[11] = '{32'h0100_0003, 1'b0, 3'd5, 32'h4B80_0002, 1'b1};
        vecs[12] = '{32'h8000_0000, 1'b1, 3'd4, 32'h4F00_0000, 1'b0};
        vecs[13] = '{32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1};
        vecs[14] = '{32'h7FFF_FFFF, 1'b0, 3'd2, 32'h4EFF_FFFF, 1'b1};
        vecs[15] = '{32'h7FFF_FFFF, 1'b0, 3'd7, 32'h4F00_0000, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_nx", 64'(fflag_nx), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Single operand latency with an idle pipeline
        begin
            int n;
            exp_q.push_back(exp_t'({32'h3F80_0000, 1'b0}));
            rs1 = 32'h1;
            is_unsigned = 1'b0;
            rm = 3'd0;
            in_valid = 1'b1;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                n++;
            end while (!out_valid && n < 10);
            chk("latency", 64'(n), 64'd3);
            drain();
        end

        // Directed vectors, back-to-back
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].uns, vecs[i].r, exp_t'({vecs[i].eo, vecs[i].enx}));
        end
        drain();

        // Five operands with a four-cycle consumer stall mid-stream
        stall_cnt = 0;
        fork
            begin
                send_m(32'h0000_0005, 1'b0, 3'd0);
                send_m(32'hFFFF_FF00, 1'b0, 3'd1);
                send_m(32'h1234_5678, 1'b0, 3'd3);
                send_m(32'hFFFF_FFFF, 1'b1, 3'd4);
                send_m(32'h0100_0001, 1'b0, 3'd2);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_cycles", 64'(stall_cnt), 64'd4);

        // Reset with three operands in flight
        send_m(32'h0000_0011, 1'b0, 3'd0);
        send_m(32'h0000_0022, 1'b0, 3'd0);
        send_m(32'h0000_0033, 1'b0, 3'd0);
        resetn = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_in_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        chk("valid_after_reset", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(32'h0, 1'b0, 3'd0, exp_t'({32'h0, 1'b0}));
        drain();

        // Randomized operands against the reference with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_m(rand_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
